prefix_adder_pipe: RTL and testbench
====================================

PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64; operand width, power of two, 8..128.
REQ-002 SHALL have parameter REG_EVERY, default 2; prefix levels per pipeline register, 1..log2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port op  input  2  00 add, 01 sub (a-b), 10 add with carry_in, 11 sub with borrow (a-b-!carry_in).
REQ-008 SHALL have port a, b  input  WIDTH  operands.
REQ-009 SHALL have port carry_in  input  1  used only by op 10/11.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port flags  output  4  {N, Z, C, V}: sign, zero, carry-out, signed overflow.

Function
REQ-014 SHALL compute b_eff = b inverted for op 01/11, c0 = 0/1/carry_in/carry_in for op 00/01/10/11.
REQ-015 SHALL form bitwise g = a&b_eff, p = a^b_eff, fold c0 in as generate of bit -1, then run log2(WIDTH) Sklansky prefix levels; level k merges bit i with the top bit of its lower 2^k-bit block via g = gL|(pL&gR), p = pL&pR.
REQ-016 SHALL register the preprocessing result (stage 0), then register after every REG_EVERY prefix levels, the last group ending with the final level; sum/flags are formed from the final register combinationally.
REQ-017 SHALL have latency LAT = 1 + ceil(log2(WIDTH)/REG_EVERY) cycles from accepted input to out_valid; WIDTH=64, REG_EVERY=2 -> LAT=4.
REQ-018 SHALL sustain one beat per cycle when out_ready is held high.
REQ-019 SHALL carry a valid bit per stage; global advance enable en = !out_valid | out_ready; in_ready = en.
REQ-020 SHALL hold all stage registers and out_valid/sum/flags stable while en=0 (stall); no beat lost or duplicated.
REQ-021 SHALL accept an input beat only when in_valid & in_ready; when en=1 and in_valid=0, insert a bubble (stage-0 valid=0).
REQ-022 SHALL set C = carry out of bit WIDTH-1 (for subtract, C=1 means no borrow), V = (a_msb==b_eff_msb) & (sum_msb!=a_msb), N = sum[WIDTH-1], Z = (sum==0).
REQ-023 SHALL wrap sum modulo 2^WIDTH; no saturation.
REQ-024 SHALL let data registers of invalid stages take any value; sum/flags are meaningful only when out_valid=1.
REQ-025 SHALL pass op-dependent control only through the g/p datapath; mixed ops in flight are independent.

Reset
REQ-026 SHALL, on rst high, clear all stage valid bits immediately (out_valid=0); in_ready=1 from the first cycle after deassert.
REQ-027 SHALL reset sum and flags to 0.
REQ-028 SHALL discard beats in flight when rst asserts mid-operation; no result for them appears after release.

Verification
REQ-029 SHALL be covered: WIDTH=64, REG_EVERY=2, op=00, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> after 4 cycles sum=0, flags N=0 Z=1 C=1 V=0.
REQ-030 SHALL be covered: op=01, a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, C=1, V=1, N=0.
REQ-031 SHALL be covered: op=11, carry_in=0, a=5, b=5 -> sum=all ones, C=0, N=1; op=10, carry_in=1, a=2, b=3 -> sum=6.
REQ-032 SHALL be covered: back-to-back 8 beats, out_ready low for 3 cycles mid-stream -> in_ready=0 during stall, all 8 results in order, none duplicated.
REQ-033 SHALL be covered: rst asserted with 3 beats in flight -> out_valid=0 immediately and stays 0 until a new beat has traversed LAT cycles.
REQ-034 SHALL be covered: random ops/operands over WIDTH in {8,32,64,128} and all legal REG_EVERY vs reference model a+b_eff+c0; latency equals REQ-017 formula.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Sklansky parallel-prefix adder/subtractor.
//
// The input beat is pre-processed into bitwise generate/propagate (carry-in folded into
// bit 0) and registered as stage 0. The log2(WIDTH) prefix levels follow, with a pipeline
// register after every REG_EVERY levels. Sum and flags are formed combinationally from
// the last register. One global advance enable stalls the whole pipe when the consumer
// is not ready, so beats are never dropped or duplicated.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset; empties the pipe
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   op         00 add, 01 a-b, 10 a+b+carry_in, 11 a-b-!carry_in
//   a, b       operands
//   carry_in   carry/borrow input for op 10/11
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   flags      {N, Z, C, V}
module prefix_adder_pipe #(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NG     = (LEVELS + REG_EVERY - 1) / REG_EVERY;  // prefix register groups
    localparam int NS     = NG + 1;                                // total stages

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] pre_g;
    logic [WIDTH-1:0] pre_p;
    logic             c0;

    // g/p: running prefix group terms; x: bitwise half-sum carried to the output stage.
    logic [WIDTH-1:0] g_q [NS];
    logic [WIDTH-1:0] p_q [NS];
    logic [WIDTH-1:0] x_q [NS];
    logic [NS-1:0]    v_q;
    logic [NS-1:0]    c0_q;
    logic [NS-1:0]    am_q;
    logic [NS-1:0]    bm_q;

    logic [WIDTH-1:0] g_nx [1:NG];
    logic [WIDTH-1:0] p_nx [1:NG];

    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] sum_raw;
    logic             c_out;
    logic             v_flag;

    assign out_valid = v_q[NS-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    always_comb begin
        b_eff = op[0] ? ~b : b;
        case (op)
            2'b00:   c0 = 1'b0;
            2'b01:   c0 = 1'b1;
            default: c0 = carry_in;
        endcase
        pre_p    = a ^ b_eff;
        pre_g    = a & b_eff;
        // Carry-in acts as the generate of bit -1; absorbing it here keeps the tree at
        // exactly log2(WIDTH) levels.
        pre_g[0] = pre_g[0] | (pre_p[0] & c0);
    end

    // Each register group applies its own slice of Sklansky levels to the previous stage.
    always_comb begin
        for (int s = 1; s < NS; s++) begin
            logic [WIDTH-1:0] gx;
            logic [WIDTH-1:0] px;
            int               j;
            gx = g_q[s-1];
            px = p_q[s-1];
            j  = 0;
            for (int k = 0; k < LEVELS; k++) begin
                if (k >= (s - 1) * REG_EVERY && k < s * REG_EVERY) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (((i >> k) & 1) == 1) begin
                            // Top bit of the lower half of this 2^(k+1) block; it has bit
                            // k clear, so it is never updated within the same level.
                            j     = ((i >> (k + 1)) << (k + 1)) + (1 << k) - 1;
                            gx[i] = gx[i] | (px[i] & gx[j]);
                            px[i] = px[i] & px[j];
                        end
                    end
                end
            end
            g_nx[s] = gx;
            p_nx[s] = px;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                g_q[s] <= '0;
                p_q[s] <= '0;
                x_q[s] <= '0;
            end
            v_q  <= '0;
            c0_q <= '0;
            am_q <= '0;
            bm_q <= '0;
        end else if (en) begin
            g_q[0] <= pre_g;
            p_q[0] <= pre_p;
            x_q[0] <= pre_p;
            for (int s = 1; s < NS; s++) begin
                g_q[s] <= g_nx[s];
                p_q[s] <= p_nx[s];
                x_q[s] <= x_q[s-1];
            end
            v_q  <= {v_q[NS-2:0], in_valid};
            c0_q <= {c0_q[NS-2:0], c0};
            am_q <= {am_q[NS-2:0], a[WIDTH-1]};
            bm_q <= {bm_q[NS-2:0], b_eff[WIDTH-1]};
        end
    end

    always_comb begin
        carry_vec = {g_q[NS-1][WIDTH-2:0], c0_q[NS-1]};
        sum_raw   = x_q[NS-1] ^ carry_vec;
        c_out     = g_q[NS-1][WIDTH-1];
        v_flag    = (am_q[NS-1] == bm_q[NS-1]) && (sum_raw[WIDTH-1] != am_q[NS-1]);
        // Gated so that both outputs read zero whenever no result is presented.
        sum       = out_valid ? sum_raw : '0;
        flags     = out_valid ? {sum_raw[WIDTH-1], sum_raw == '0, c_out, v_flag} : 4'b0000;
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed scoreboard tests on the default 64-bit/2-level
// configuration plus a sweep over widths 8/32/64/128 and every REG_EVERY value.
module tb_prefix_adder_pipe;
    localparam int W     = 64;
    localparam int LAT   = 4;
    localparam int NINST = 21;
    localparam int NB    = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    always #5 clk = ~clk;

    // Default-configuration DUT.
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          carry_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic [3:0]    flags;

    prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a),
        .b(b), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .flags(flags)
    );

    // Sweep instances, all fed the same beat stream.
    logic               r_in_valid = 1'b0;
    logic [1:0]         r_op = 2'b00;
    logic [127:0]       r_a = '0;
    logic [127:0]       r_b = '0;
    logic               r_ci = 1'b0;
    logic [NINST-1:0]   r_v;
    logic [NINST-1:0]   r_ir;
    logic [127:0]       r_sum [NINST];
    logic [3:0]         r_fl  [NINST];

    function automatic int inst_w(int idx);
        if (idx < 3) return 8;
        if (idx < 8) return 32;
        if (idx < 14) return 64;
        return 128;
    endfunction

    function automatic int inst_r(int idx);
        if (idx < 3) return idx + 1;
        if (idx < 8) return idx - 2;
        if (idx < 14) return idx - 7;
        return idx - 13;
    endfunction

    function automatic int inst_lat(int idx);
        int l;
        l = $clog2(inst_w(idx));
        return 1 + (l + inst_r(idx) - 1) / inst_r(idx);
    endfunction

    for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
        localparam int IW = inst_w(gi);
        localparam int IR = inst_r(gi);
        logic [IW-1:0] s;
        logic [3:0]    f;
        logic          v;
        logic          ir;
        prefix_adder_pipe #(.WIDTH(IW), .REG_EVERY(IR)) u_sweep (
            .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(ir), .op(r_op),
            .a(r_a[IW-1:0]), .b(r_b[IW-1:0]), .carry_in(r_ci), .out_valid(v),
            .out_ready(1'b1), .sum(s), .flags(f)
        );
        assign r_v[gi]   = v;
        assign r_ir[gi]  = ir;
        assign r_sum[gi] = 128'(s);
        assign r_fl[gi]  = f;
    end

    // Behavioural reference: plain wide addition, truncated to the instance width.
    function automatic logic [131:0] model(int w, logic [1:0] o, logic [127:0] x,
                                           logic [127:0] y, logic ci);
        logic [128:0] mask, am, bm, s;
        logic [127:0] sm;
        logic         c0, n, z, c, v;
        mask = (129'd1 << w) - 129'd1;
        am   = {1'b0, x} & mask;
        bm   = o[0] ? ({1'b0, ~y} & mask) : ({1'b0, y} & mask);
        c0   = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : ci;
        s    = am + bm + 129'(c0);
        c    = s[w];
        sm   = s[127:0] & mask[127:0];
        n    = sm[w-1];
        z    = (sm == '0);
        v    = (am[w-1] == bm[w-1]) && (n != am[w-1]);
        return {n, z, c, v, sm};
    endfunction

    typedef struct packed {
        logic [W-1:0] s;
        logic [3:0]   f;
    } exp_t;

    typedef struct packed {
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic [W-1:0] s;
        logic [3:0]   f;
    } vec_t;

    exp_t exp_q [$];
    vec_t vecs [10];
    int   checks   = 0;
    int   errors   = 0;
    int   sent     = 0;
    int   received = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sum %0h with empty scoreboard", sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 128'(sum), 128'(e.s));
                    check("flags", 128'(flags), 128'(e.f));
                    received++;
                end
            end
        end
    end

    task automatic send(vec_t t);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        op       = t.o;
        a        = t.x;
        b        = t.y;
        carry_in = t.ci;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) begin
            exp_q.push_back('{s: t.s, f: t.f});
            sent++;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 128'(exp_q.size()), 128'd0);
    endtask

    // Called right after the acceptance edge; counts that edge as cycle 1.
    task automatic measure_latency(string name);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(name, 128'(cyc), 128'(LAT));
    endtask

    task automatic drive_sweep(logic [1:0] o, logic [127:0] x, logic [127:0] y, logic ci);
        r_in_valid = 1'b1;
        r_op       = o;
        r_a        = x;
        r_b        = y;
        r_ci       = ci;
    endtask

    logic [1:0]   rop [NB];
    logic [127:0] ra  [NB];
    logic [127:0] rb  [NB];
    logic         rci [NB];

    initial begin
        vecs[0] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110};
        vecs[1] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                    64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        vecs[2] = '{2'b11, 64'd5, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
        vecs[3] = '{2'b10, 64'd2, 64'd3, 1'b1, 64'd6, 4'b0000};
        vecs[4] = '{2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 4'b0100};
        vecs[5] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                    64'h8000_0000_0000_0000, 4'b1001};
        vecs[6] = '{2'b01, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
        vecs[7] = '{2'b01, 64'd5, 64'd5, 1'b0, 64'd0, 4'b0110};
        vecs[8] = '{2'b10, 64'd10, 64'd20, 1'b0, 64'd30, 4'b0000};
        vecs[9] = '{2'b11, 64'd10, 64'd3, 1'b1, 64'd7, 4'b0010};

        // Reset state.
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_sum", 128'(sum), 128'd0);
        check("rst_flags", 128'(flags), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Single beats, including first-result latency.
        send(vecs[0]);
        measure_latency("latency_first");
        drain();
        for (int i = 1; i < 4; i++) begin
            send(vecs[i]);
            drain();
        end

        // Eight back-to-back beats with a three-cycle consumer stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i + 2]);
            end
            begin
                logic [W-1:0] held_s;
                logic [3:0]   held_f;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held_s = sum;
                held_f = flags;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        check("stall_hold_sum", 128'(sum), 128'(held_s));
                        check("stall_hold_flags", 128'(flags), 128'(held_f));
                    end
                    check("stall_in_ready", 128'(in_ready), 128'd0);
                    check("stall_out_valid", 128'(out_valid), 128'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("no_loss_no_dup", 128'(received), 128'(sent));

        // Reset with three beats in flight: they must vanish.
        for (int i = 4; i < 7; i++) send(vecs[i]);
        rst = 1'b1;
        exp_q.delete();
        sent = received;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_quiet", 128'(out_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        send(vecs[8]);
        measure_latency("latency_after_rst");
        drain();
        check("midrst_count", 128'(received), 128'(sent));

        // Sweep: one beat per cycle into every width/REG_EVERY instance.
        for (int k = 0; k < NB; k++) begin
            rop[k] = 2'($urandom_range(0, 3));
            ra[k]  = {$urandom, $urandom, $urandom, $urandom};
            rb[k]  = {$urandom, $urandom, $urandom, $urandom};
            rci[k] = 1'($urandom_range(0, 1));
        end
        rop[0] = 2'b00; ra[0] = '1; rb[0] = 128'd1;
        rop[1] = 2'b01; ra[1] = '0; rb[1] = '0;
        rop[2] = 2'b11; ra[2] = 128'd5; rb[2] = 128'd5; rci[2] = 1'b0;
        drive_sweep(rop[0], ra[0], rb[0], rci[0]);
        for (int c = 1; c <= NB + 9; c++) begin
            @(posedge clk);
            #1;
            for (int n = 0; n < NINST; n++) begin
                int           idx;
                logic         expv;
                logic [131:0] m;
                idx  = c - inst_lat(n);
                expv = (idx >= 0 && idx < NB);
                check($sformatf("sweep%0d_valid", n), 128'(r_v[n]), 128'(expv));
                check($sformatf("sweep%0d_in_ready", n), 128'(r_ir[n]), 128'd1);
                if (expv) begin
                    m = model(inst_w(n), rop[idx], ra[idx], rb[idx], rci[idx]);
                    check($sformatf("sweep%0d_sum_beat%0d", n, idx), r_sum[n], m[127:0]);
                    check($sformatf("sweep%0d_flags_beat%0d", n, idx), 128'(r_fl[n]),
                          128'(m[131:128]));
                end
            end
            if (c < NB) drive_sweep(rop[c], ra[c], rb[c], rci[c]);
            else r_in_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
